// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - instruction layout (11-bit word: [10:8] opcode, [7:0] operand)
//   - opcode encodings OP_NOP .. OP_HALT
//   - FSM state encoding (ST_STALL exists only when ALU_SEQ_SINGLE_STEP_EN is defined)
//   - is_alu_op(): true for the opcodes that go through the external ALU
package alu_seq_pkg;

  localparam int INSTR_W = 11;
  localparam int OPC_MSB = 10;
  localparam int OPC_LSB = 8;
  localparam int IMM_MSB = 7;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_INC  = 3'b011;
  localparam logic [2:0] OP_SHR2 = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_JNZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
`ifdef ALU_SEQ_SINGLE_STEP_EN
    , ST_STALL = 3'd6
`endif
  } state_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_SHR2);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bus between the sequencer and its neighbours.
//   imem side : imem_req, imem_addr (to memory), imem_data, imem_ack (from memory)
//   ALU side  : alu_opcode, alu_in1, alu_in2 (to ALU), alu_out (registered ALU result)
// Modports: master = sequencer, slave = memory/ALU environment.
interface alu_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 10,
  parameter int IMM_W  = 8
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_ack;
  logic [2:0]         alu_opcode;
  logic [IMM_W-1:0]   alu_in1;
  logic [DATA_W-1:0]  alu_in2;
  logic [DATA_W-1:0]  alu_out;

  modport master (
    output imem_req, imem_addr, alu_opcode, alu_in1, alu_in2,
    input  imem_data, imem_ack, alu_out
  );

  modport slave (
    input  imem_req, imem_addr, alu_opcode, alu_in1, alu_in2,
    output imem_data, imem_ack, alu_out
  );
endinterface

// File: rtl/alu_seq_fetch.sv
// alu_seq_fetch: instruction fetch handshake.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_fetch  high for every cycle the sequencer sits in FETCH
//   addr         fetch address (PC)
//   imem_*       request/ack handshake to instruction memory
//   done         ack seen this cycle; instruction is latched at the clock edge
//   err          FETCH_TIMEOUT cycles elapsed without ack (one-cycle strobe)
//   instr        last latched instruction
module alu_seq_fetch
  import alu_seq_pkg::*;
#(
  parameter int PC_W          = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_fetch,
  input  logic [PC_W-1:0]    addr,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_ack,
  output logic               done,
  output logic               err,
  output logic [INSTR_W-1:0] instr
);

  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  assign imem_req  = start_fetch;
  assign imem_addr = addr;
  // ack outside a request is meaningless and must not complete a fetch
  assign done      = start_fetch & imem_ack;
  // An ack in the final allowed cycle still wins over the timeout
  assign err       = start_fetch & ~imem_ack & (cnt_q == CNT_W'(FETCH_TIMEOUT - 1));
  assign instr     = instr_q;

  always_comb begin
    cnt_d   = cnt_q;
    instr_d = instr_q;
    if (!start_fetch) begin
      // Clearing while idle restarts the count on every entry to FETCH
      cnt_d = '0;
    end else if (imem_ack) begin
      instr_d = imem_data;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: control stage in front of the accumulator ALU.
// Fetches 11-bit instructions, decodes them, drives the ALU and writes its
// registered result back into the accumulator. Owns PC, acc, branches, halt
// and the sticky fetch-timeout error.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       pulse; restarts execution at RESET_PC from IDLE or HALTED
//   step        (only with ALU_SEQ_SINGLE_STEP_EN) releases the FSM from STALL
//   bus         master side of alu_sequencer_if (imem handshake + ALU operands)
//   acc_out     accumulator, pc_out program counter (debug)
//   busy        high outside IDLE/HALTED; halted: in HALTED; fetch_err: sticky
// Optional feature macro: ALU_SEQ_SINGLE_STEP_EN (single-step STALL state).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W          = 8,
  parameter int DATA_W        = 10,
  parameter int IMM_W         = 8,
  parameter int RESET_PC      = 0,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef ALU_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  alu_sequencer_if.master   bus,
  output logic [DATA_W-1:0] acc_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err
);

  // Where the FSM goes after an instruction completes without halting
`ifdef ALU_SEQ_SINGLE_STEP_EN
  localparam state_t ST_RESUME = ST_STALL;
`else
  localparam state_t ST_RESUME = ST_FETCH;
`endif

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                err_q, err_d;

  logic                fetch_active;
  logic                fetch_done;
  logic                fetch_timeout;
  logic [INSTR_W-1:0]  instr;
  logic [2:0]          opc;
  logic [IMM_MSB:0]    imm;

  assign fetch_active = (state_q == ST_FETCH);
  assign opc          = instr[OPC_MSB:OPC_LSB];
  assign imm          = instr[IMM_MSB:0];

  alu_seq_fetch #(
    .PC_W          (PC_W),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch (
    .clk         (clk),
    .rst         (rst),
    .start_fetch (fetch_active),
    .addr        (pc_q),
    .imem_req    (bus.imem_req),
    .imem_addr   (bus.imem_addr),
    .imem_data   (bus.imem_data),
    .imem_ack    (bus.imem_ack),
    .done        (fetch_done),
    .err         (fetch_timeout),
    .instr       (instr)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = PC_W'(RESET_PC);
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (fetch_done) begin
          pc_d    = pc_q + PC_W'(1);  // wraps naturally at 2^PC_W
          state_d = ST_DECODE;
        end else if (fetch_timeout) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end
      end
      ST_DECODE: begin
        if (is_alu_op(opc)) begin
          state_d = ST_EXEC;
        end else begin
          case (opc)
            OP_LDI: begin
              acc_d   = DATA_W'(imm);
              state_d = ST_RESUME;
            end
            OP_JNZ: begin
              // Uses the live accumulator; the ALU's own flags lag a cycle
              if (acc_q != '0) pc_d = PC_W'(imm);
              state_d = ST_RESUME;
            end
            OP_HALT: state_d = ST_HALTED;
            default: state_d = ST_RESUME;  // NOP
          endcase
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        acc_d   = bus.alu_out;
        state_d = ST_RESUME;
      end
`ifdef ALU_SEQ_SINGLE_STEP_EN
      ST_STALL: begin
        if (step) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // The ALU only sees a real opcode during EXEC; 000 elsewhere makes it hold
  always_comb begin
    bus.alu_opcode = OP_NOP;
    bus.alu_in1    = '0;
    if (state_q == ST_EXEC) begin
      bus.alu_opcode = opc;
      bus.alu_in1    = IMM_W'(imm);
    end
  end

  assign bus.alu_in2 = acc_q;
  assign acc_out     = acc_q;
  assign pc_out      = pc_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted      = (state_q == ST_HALTED);
  assign fetch_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_W'(RESET_PC);
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: instruction memory and registered ALU models,
// an ISA-level reference interpreter that queues expected fetches, and a
// monitor that checks every fetch handshake against that queue.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int PC_W   = 8;
  localparam int DATA_W = 10;
  localparam int IMM_W  = 8;
  localparam int MOD    = 1 << DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
`endif
  logic [DATA_W-1:0] acc_out;
  logic [PC_W-1:0]   pc_out;
  logic              busy, halted, fetch_err;

  alu_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

  alu_sequencer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .IMM_W(IMM_W), .RESET_PC(0), .FETCH_TIMEOUT(15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef ALU_SEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .busy      (busy),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction memory model ----------------
  logic [INSTR_W-1:0] mem [256];
  bit ack_en    = 1'b1;
  int max_delay = 0;
  int wait_cnt  = 0;
  int cur_delay = 0;
  bit noise     = 1'b0;

  always @(posedge clk) begin
    noise <= 1'($urandom_range(0, 1));
    if (rst || !bus.imem_req) begin
      wait_cnt <= 0;
    end else if (bus.imem_ack) begin
      wait_cnt  <= 0;
      cur_delay <= int'($urandom_range(0, max_delay));
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Random ack noise while no request is pending must be ignored by the DUT
  always_comb begin
    bus.imem_data = mem[bus.imem_addr];
    bus.imem_ack  = bus.imem_req ? (ack_en && (wait_cnt >= cur_delay)) : noise;
  end

  // ---------------- registered ALU model ----------------
  always @(posedge clk) begin
    int a, b;
    a = int'(bus.alu_in2);
    b = int'(bus.alu_in1);
    case (bus.alu_opcode)
      OP_ADD:  bus.alu_out <= DATA_W'((a + b) % MOD);
      OP_SUB:  bus.alu_out <= DATA_W'((a - b + MOD) % MOD);
      OP_INC:  bus.alu_out <= DATA_W'((a + 1) % MOD);
      OP_SHR2: bus.alu_out <= DATA_W'(a / 4);
      default: ;
    endcase
  end

  // ---------------- reference interpreter + scoreboard ----------------
  typedef struct { int addr; int acc; } fetch_t;
  fetch_t exp_q[$];
  int m_acc = 0;
  int m_pc  = 0;

  task automatic run_model(input int max_steps);
    int pc = 0;
    int steps = 0;
    bit done = 0;
    while (!done && steps < max_steps) begin
      int op, im;
      exp_q.push_back('{addr: pc, acc: m_acc});
      op = int'(mem[pc][10:8]);
      im = int'(mem[pc][7:0]);
      pc = (pc + 1) % 256;
      case (op)
        1: m_acc = (m_acc + im) % MOD;
        2: m_acc = (m_acc - im + MOD) % MOD;
        3: m_acc = (m_acc + 1) % MOD;
        4: m_acc = m_acc / 4;
        5: m_acc = im;
        6: if (m_acc != 0) pc = im;
        7: done = 1;
        default: ;
      endcase
      steps++;
    end
    m_pc = pc;
  endtask

  always @(negedge clk) begin
    fetch_t e;
    if (!rst && bus.imem_req && bus.imem_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fetch", int'(bus.imem_addr), -1);
      end else begin
        e = exp_q.pop_front();
        check("fetch_addr", int'(bus.imem_addr), e.addr);
        check("fetch_acc", int'(acc_out), e.acc);
        $display("fetch addr=%0h acc=%0d", bus.imem_addr, acc_out);
      end
    end
  end

  int add_cycles = 0;
  always @(negedge clk) if (bus.alu_opcode == OP_ADD) add_cycles++;

  // ---------------- helpers ----------------
  function automatic logic [INSTR_W-1:0] ins(input logic [2:0] op, input int im);
    return {op, 8'(im)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = ins(OP_HALT, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halted_within_budget", int'(halted), 1);
  endtask

  task automatic run_program(input int budget);
    run_model(500);
    pulse_start();
    check("err_cleared_on_start", int'(fetch_err), 0);
    wait_halted(budget);
    check("final_pc", int'(pc_out), m_pc);
    check("final_acc", int'(acc_out), m_acc);
    check("queue_drained", exp_q.size(), 0);
    $display("program done pc=%0h acc=%0d", pc_out, acc_out);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, int'(bus.imem_req), 0);
    check({tag, "_alu_opcode"}, int'(bus.alu_opcode), 0);
    check({tag, "_alu_in1"}, int'(bus.alu_in1), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_halted"}, int'(halted), 0);
    check({tag, "_fetch_err"}, int'(fetch_err), 0);
    check({tag, "_acc"}, int'(acc_out), 0);
    check({tag, "_pc"}, int'(pc_out), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, n, len;
    clear_mem();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // LDI 5, ADD 3, SUB 1, HALT
    mem[0] = ins(OP_LDI, 5);
    mem[1] = ins(OP_ADD, 3);
    mem[2] = ins(OP_SUB, 1);
    mem[3] = ins(OP_HALT, 0);
    base = add_cycles;
    run_program(100);
    check("p1_acc", int'(acc_out), 7);
    check("p1_pc", int'(pc_out), 4);
    check("p1_add_cycles", add_cycles - base, 1);

    // Branch not taken, then taken to 0x20
    clear_mem();
    mem[0]    = ins(OP_LDI, 0);
    mem[1]    = ins(OP_JNZ, 8'h10);
    mem[2]    = ins(OP_INC, 0);
    mem[3]    = ins(OP_JNZ, 8'h20);
    mem[8'h10] = ins(OP_LDI, 99);
    mem[8'h20] = ins(OP_HALT, 0);
    run_program(100);
    check("p2_pc", int'(pc_out), 8'h21);
    check("p2_acc", int'(acc_out), 1);

    // Fetch timeout: 15 cycles without ack
    ack_en = 1'b0;
    pulse_start();
    check("to_req_first", int'(bus.imem_req), 1);
    check("to_addr_first", int'(bus.imem_addr), 0);
    repeat (14) @(negedge clk);
    check("to_req_cycle15", int'(bus.imem_req), 1);
    check("to_err_cycle15", int'(fetch_err), 0);
    @(negedge clk);
    check("to_err", int'(fetch_err), 1);
    check("to_halted", int'(halted), 1);
    check("to_req_dropped", int'(bus.imem_req), 0);
    ack_en = 1'b1;
    run_program(100);

    // PC wrap 0xFF -> 0x00 (acc is non-zero here, so JNZ is taken)
    clear_mem();
    mem[0]     = ins(OP_JNZ, 8'hFE);
    mem[8'hFE] = ins(OP_LDI, 0);
    mem[8'hFF] = ins(OP_NOP, 0);
    run_program(100);
    check("wrap_pc", int'(pc_out), 2);

    // Randomized forward-branching programs with random ack latency
    max_delay = 3;
    for (int t = 0; t < 12; t++) begin
      clear_mem();
      len = int'($urandom_range(4, 12));
      for (int i = 0; i < len - 1; i++) begin
        int op, im;
        op = int'($urandom_range(0, 6));
        im = int'($urandom_range(0, 255));
        if (op == 6) im = int'($urandom_range(i + 1, len - 1));
        mem[i] = ins(3'(op), im);
      end
      run_program(500);
    end
    max_delay = 0;

    // Reset asserted during EXEC of ADD
    clear_mem();
    mem[0] = ins(OP_LDI, 5);
    mem[1] = ins(OP_ADD, 3);
    mem[2] = ins(OP_HALT, 0);
    run_model(100);
    pulse_start();
    n = 0;
    while (bus.alu_opcode != OP_ADD && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_exec", int'(bus.alu_opcode), int'(OP_ADD));
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    exp_q.delete();
    m_acc = 0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("postrst_acc", int'(acc_out), 0);
    check("postrst_busy", int'(busy), 0);
    check("postrst_halted", int'(halted), 0);

`ifdef ALU_SEQ_SINGLE_STEP_EN
    // Single-step: park in STALL after LDI, start is ignored there
    clear_mem();
    mem[0] = ins(OP_LDI, 2);
    mem[1] = ins(OP_INC, 0);
    step = 1'b0;
    run_model(100);
    pulse_start();
    repeat (6) @(negedge clk);
    check("stall_acc", int'(acc_out), 2);
    check("stall_busy", int'(busy), 1);
    check("stall_req", int'(bus.imem_req), 0);
    pulse_start();
    repeat (2) @(negedge clk);
    check("stall_pc_after_start", int'(pc_out), 1);
    check("stall_req_after_start", int'(bus.imem_req), 0);
    step = 1'b1;
    wait_halted(100);
    check("step_acc", int'(acc_out), 3);
    check("step_pc", int'(pc_out), 3);
    check("step_queue", exp_q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
